// File: rtl/piece_move_resolver.sv
// piece_move_resolver
//    Resolves one tetromino move request (shift, drop or rotation) against
//    a 6x6 occupancy window around the piece box. The window comes from an
//    external mask generator that is addressed by the registered
//    piece_x/piece_y origin.
//
//    Optional wall kicks are enabled by defining PIECE_MOVE_RESOLVER_WALL_KICK_EN.
//    When enabled, a blocked rotation is retried one column left and then
//    one column right before it is rejected.
//
// Ports
//    clk, reset                  clock; synchronous active-high reset
//    move_valid / move_ready     request handshake (ready only while idle)
//    move_cmd, piece_type        command (0..4 legal) and tetromino (0..6 legal)
//    cur_x, cur_y, cur_rot       current piece-box origin and rotation
//    piece_x, piece_y            window origin driven to the mask generator
//    window                      window[lx][ly] = cell (piece_x+lx-1, piece_y+ly-1)
//    result_valid / result_ready result handshake
//    result_ok, result_lock      move applied / blocked DOWN (piece must lock)
//    new_x, new_y, new_rot       resolved position (latched cur_* on reject)

module piece_move_resolver #(
    parameter int BOARD_WIDTH  = 10,
    parameter int BOARD_HEIGHT = 20
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            move_valid,
    output logic                            move_ready,
    input  logic [2:0]                      move_cmd,
    input  logic [2:0]                      piece_type,
    input  logic [$clog2(BOARD_WIDTH)-1:0]  cur_x,
    input  logic [$clog2(BOARD_HEIGHT)-1:0] cur_y,
    input  logic [1:0]                      cur_rot,
    output logic [$clog2(BOARD_WIDTH)-1:0]  piece_x,
    output logic [$clog2(BOARD_HEIGHT)-1:0] piece_y,
    input  logic [5:0][5:0]                 window,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic                            result_ok,
    output logic                            result_lock,
    output logic [$clog2(BOARD_WIDTH)-1:0]  new_x,
    output logic [$clog2(BOARD_HEIGHT)-1:0] new_y,
    output logic [1:0]                      new_rot
);

    // state  | meaning
    // IDLE   | waiting for a move request (move_ready high)
    // SAMPLE | request latched, window settling for the new origin
    // CHECK  | bounds and collision test of the candidate position
    // KICK_L | (kicks only) blocked rotation retried at dx=-1
    // KICK_R | (kicks only) blocked rotation retried at dx=+1
    // RESP   | result held until result_ready

    localparam int XW = $clog2(BOARD_WIDTH);
    localparam int YW = $clog2(BOARD_HEIGHT);

    localparam logic [2:0] CMD_LEFT    = 3'd0;
    localparam logic [2:0] CMD_RIGHT   = 3'd1;
    localparam logic [2:0] CMD_DOWN    = 3'd2;
    localparam logic [2:0] CMD_ROT_CW  = 3'd3;
    localparam logic [2:0] CMD_ROT_CCW = 3'd4;

`ifdef PIECE_MOVE_RESOLVER_WALL_KICK_EN
    typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, KICK_L, KICK_R, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, RESP} state_t;
`endif

    state_t          state;
    logic [2:0]      cmd_q;
    logic [2:0]      type_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [1:0]      rot_q;

    // Shape masks, bit index sy*4+sx. Rotations are clockwise quarter turns
    // inside the 4x4 box (I, O) or the upper-left 3x3 box (T, S, Z, J, L).
    function automatic logic [15:0] shape_rom(input logic [2:0] ptype, input logic [1:0] rot);
        logic [15:0] m;
        m = 16'h0000;
        case ({ptype, rot})
            5'b000_00: m = 16'h00F0;
            5'b000_01: m = 16'h4444;
            5'b000_10: m = 16'h0F00;
            5'b000_11: m = 16'h2222;
            5'b001_00, 5'b001_01, 5'b001_10, 5'b001_11: m = 16'h0066;
            5'b010_00: m = 16'h0072;
            5'b010_01: m = 16'h0262;
            5'b010_10: m = 16'h0270;
            5'b010_11: m = 16'h0232;
            5'b011_00: m = 16'h0036;
            5'b011_01: m = 16'h0462;
            5'b011_10: m = 16'h0360;
            5'b011_11: m = 16'h0231;
            5'b100_00: m = 16'h0063;
            5'b100_01: m = 16'h0264;
            5'b100_10: m = 16'h0630;
            5'b100_11: m = 16'h0132;
            5'b101_00: m = 16'h0071;
            5'b101_01: m = 16'h0226;
            5'b101_10: m = 16'h0470;
            5'b101_11: m = 16'h0322;
            5'b110_00: m = 16'h0074;
            5'b110_01: m = 16'h0622;
            5'b110_10: m = 16'h0170;
            5'b110_11: m = 16'h0223;
            default:   m = 16'h0000;
        endcase
        return m;
    endfunction

    // The window has a one-cell margin around the box, so every candidate
    // offset (dx in -1..1, dy in 0..1) stays inside the 6x6 window.
    function automatic logic collides(input logic [15:0] shape, input logic [5:0][5:0] win,
                                      input logic signed [2:0] dx, input logic [1:0] dy);
        logic       hit;
        logic [2:0] lx;
        logic [2:0] ly;
        hit = 1'b0;
        for (int sy = 0; sy < 4; sy++) begin
            for (int sx = 0; sx < 4; sx++) begin
                lx = 3'(sx + 1 + int'(dx));
                ly = 3'(sy + 1 + int'(dy));
                if (shape[4'(sy * 4 + sx)] && win[lx][ly]) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    logic              legal;
    logic              fail_lock;
    logic signed [2:0] base_dx;
    logic signed [2:0] chk_dx;
    logic [1:0]        base_dy;
    logic [1:0]        cand_rot;
    int                cand_x;
    int                cand_y;
    logic              in_bounds;
    logic              hit;
    logic              pass;

    assign legal     = (cmd_q <= CMD_ROT_CCW) && (type_q != 3'd7);
    assign fail_lock = legal && (cmd_q == CMD_DOWN);

`ifdef PIECE_MOVE_RESOLVER_WALL_KICK_EN
    logic is_rot;
    assign is_rot = legal && ((cmd_q == CMD_ROT_CW) || (cmd_q == CMD_ROT_CCW));
`endif

    // Moves never go up, so the top window row is never consulted.
    logic window_row0_unused;
    assign window_row0_unused = ^{window[0][0], window[1][0], window[2][0],
                                  window[3][0], window[4][0], window[5][0]};

    always_comb begin
        base_dx  = 3'sd0;
        base_dy  = 2'd0;
        cand_rot = rot_q;
        case (cmd_q)
            CMD_LEFT:    base_dx  = -3'sd1;
            CMD_RIGHT:   base_dx  = 3'sd1;
            CMD_DOWN:    base_dy  = 2'd1;
            CMD_ROT_CW:  cand_rot = rot_q + 2'd1;
            CMD_ROT_CCW: cand_rot = rot_q - 2'd1;
            default:     ;
        endcase
        chk_dx = base_dx;
`ifdef PIECE_MOVE_RESOLVER_WALL_KICK_EN
        if (state == KICK_L)      chk_dx = -3'sd1;
        else if (state == KICK_R) chk_dx = 3'sd1;
`endif
        cand_x    = int'(x_q) + int'(chk_dx);
        cand_y    = int'(y_q) + int'(base_dy);
        in_bounds = (cand_x >= 0) && (cand_x <= BOARD_WIDTH - 1) && (cand_y <= BOARD_HEIGHT - 1);
        hit       = collides(shape_rom(type_q, cand_rot), window, chk_dx, base_dy);
        pass      = legal && in_bounds && !hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            move_ready   <= 1'b0;
            result_valid <= 1'b0;
            result_ok    <= 1'b0;
            result_lock  <= 1'b0;
            piece_x      <= '0;
            piece_y      <= '0;
            new_x        <= '0;
            new_y        <= '0;
            new_rot      <= '0;
            cmd_q        <= '0;
            type_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            rot_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    move_ready <= 1'b1;
                    if (move_valid && move_ready) begin
                        cmd_q      <= move_cmd;
                        type_q     <= piece_type;
                        x_q        <= cur_x;
                        y_q        <= cur_y;
                        rot_q      <= cur_rot;
                        piece_x    <= cur_x;
                        piece_y    <= cur_y;
                        move_ready <= 1'b0;
                        state      <= SAMPLE;
                    end
                end
                SAMPLE: state <= CHECK;
                CHECK: begin
                    if (pass) begin
                        result_valid <= 1'b1;
                        result_ok    <= 1'b1;
                        result_lock  <= 1'b0;
                        new_x        <= XW'(cand_x);
                        new_y        <= YW'(cand_y);
                        new_rot      <= cand_rot;
                        state        <= RESP;
                    end
`ifdef PIECE_MOVE_RESOLVER_WALL_KICK_EN
                    else if (is_rot) begin
                        state <= KICK_L;
                    end
`endif
                    else begin
                        result_valid <= 1'b1;
                        result_ok    <= 1'b0;
                        result_lock  <= fail_lock;
                        new_x        <= x_q;
                        new_y        <= y_q;
                        new_rot      <= rot_q;
                        state        <= RESP;
                    end
                end
`ifdef PIECE_MOVE_RESOLVER_WALL_KICK_EN
                KICK_L: begin
                    if (pass) begin
                        result_valid <= 1'b1;
                        result_ok    <= 1'b1;
                        result_lock  <= 1'b0;
                        new_x        <= XW'(cand_x);
                        new_y        <= YW'(cand_y);
                        new_rot      <= cand_rot;
                        state        <= RESP;
                    end else begin
                        state <= KICK_R;
                    end
                end
                KICK_R: begin
                    result_valid <= 1'b1;
                    result_ok    <= pass;
                    result_lock  <= 1'b0;
                    new_x        <= pass ? XW'(cand_x) : x_q;
                    new_y        <= y_q;
                    new_rot      <= pass ? cand_rot : rot_q;
                    state        <= RESP;
                end
`endif
                RESP: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        move_ready   <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_move_resolver.sv
// tb_piece_move_resolver
//    Randomised and directed moves against a board-level reference model.
//    The bench plays the mask generator: it derives the window from its own
//    board array and the DUT's piece_x/piece_y origin.

`timescale 1ns/1ps

module tb_piece_move_resolver;
    localparam int BW = 10;
    localparam int BH = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             move_valid = 1'b0;
    logic             move_ready;
    logic [2:0]       move_cmd = '0;
    logic [2:0]       piece_type = '0;
    logic [3:0]       cur_x = '0;
    logic [4:0]       cur_y = '0;
    logic [1:0]       cur_rot = '0;
    logic [3:0]       piece_x;
    logic [4:0]       piece_y;
    logic [5:0][5:0]  window;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic             result_ok;
    logic             result_lock;
    logic [3:0]       new_x;
    logic [4:0]       new_y;
    logic [1:0]       new_rot;

    piece_move_resolver #(.BOARD_WIDTH(BW), .BOARD_HEIGHT(BH)) dut (
        .clk(clk), .reset(reset),
        .move_valid(move_valid), .move_ready(move_ready),
        .move_cmd(move_cmd), .piece_type(piece_type),
        .cur_x(cur_x), .cur_y(cur_y), .cur_rot(cur_rot),
        .piece_x(piece_x), .piece_y(piece_y), .window(window),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_ok(result_ok), .result_lock(result_lock),
        .new_x(new_x), .new_y(new_y), .new_rot(new_rot)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit [BW-1:0] board [BH];

    // Spawn-orientation cells of I, O, T, S, Z, J, L as (x, y) in the box.
    int base_x [7][4] = '{'{0,1,2,3}, '{1,2,1,2}, '{1,0,1,2}, '{1,2,0,1},
                          '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};
    int base_y [7][4] = '{'{1,1,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,0,1,1},
                          '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit occupied(input int x, input int y);
        if (x < 0 || x >= BW || y < 0 || y >= BH) return 1'b1;
        return board[y][x];
    endfunction

    // Piece fits with its box origin at (px, py): origin in range and every
    // cell (rotated clockwise rot times) on an empty board square.
    function automatic bit fits(input int ptype, input int rot, input int px, input int py);
        int x, y, t;
        if (px < 0 || px > BW - 1 || py > BH - 1) return 1'b0;
        for (int c = 0; c < 4; c++) begin
            x = base_x[ptype][c];
            y = base_y[ptype][c];
            for (int k = 0; k < rot; k++) begin
                t = x;
                if (ptype == 0)      begin x = 3 - y; y = t; end
                else if (ptype != 1) begin x = 2 - y; y = t; end
            end
            if (occupied(px + x, py + y)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model(input int cmd, input int ptype, input int x, input int y, input int rot,
                         output int ok, output int lock, output int nx, output int ny,
                         output int nrot, output int lat);
        int dx, dy, r2;
        ok = 0; lock = 0; nx = x; ny = y; nrot = rot; lat = 2;
        if (cmd > 4 || ptype > 6) return;
        dx = (cmd == 0) ? -1 : (cmd == 1) ? 1 : 0;
        dy = (cmd == 2) ? 1 : 0;
        r2 = (cmd == 3) ? (rot + 1) % 4 : (cmd == 4) ? (rot + 3) % 4 : rot;
        if (fits(ptype, r2, x + dx, y + dy)) begin
            ok = 1; nx = x + dx; ny = y + dy; nrot = r2;
            return;
        end
`ifdef PIECE_MOVE_RESOLVER_WALL_KICK_EN
        if (cmd >= 3) begin
            lat = 3;
            if (fits(ptype, r2, x - 1, y)) begin ok = 1; nx = x - 1; nrot = r2; return; end
            lat = 4;
            if (fits(ptype, r2, x + 1, y)) begin ok = 1; nx = x + 1; nrot = r2; return; end
            return;
        end
`endif
        lock = (cmd == 2) ? 1 : 0;
    endtask

    always @(negedge clk) begin
        for (int lx = 0; lx < 6; lx++)
            for (int ly = 0; ly < 6; ly++)
                window[lx][ly] = occupied(int'(piece_x) + lx - 1, int'(piece_y) + ly - 1);
    end

    task automatic clear_board();
        for (int y = 0; y < BH; y++) board[y] = '0;
    endtask

    task automatic fill_board(input int pct);
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                board[y][x] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!move_ready && w < 20) begin @(negedge clk); w++; end
        check_val({tag, "/ready"}, 32'(move_ready), 32'd1);
    endtask

    task automatic run_move(input int cmd, input int ptype, input int x, input int y,
                            input int rot, input int hold, input string tag);
        int e_ok, e_lock, e_x, e_y, e_rot, e_lat, cyc;
        model(cmd, ptype, x, y, rot, e_ok, e_lock, e_x, e_y, e_rot, e_lat);
        wait_ready(tag);
        move_cmd = 3'(cmd); piece_type = 3'(ptype);
        cur_x = 4'(x); cur_y = 5'(y); cur_rot = 2'(rot);
        move_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        // The request is latched; later input changes must not matter.
        cur_x = 4'($urandom_range(0, 15));
        cur_y = 5'($urandom_range(0, 31));
        cur_rot = 2'($urandom_range(0, 3));
        move_cmd = 3'($urandom_range(0, 7));
        piece_type = 3'($urandom_range(0, 7));
        check_val({tag, "/piece_x"}, 32'(piece_x), x);
        check_val({tag, "/piece_y"}, 32'(piece_y), y);
        cyc = 0;
        do begin
            @(posedge clk); cyc++; @(negedge clk);
        end while (!result_valid && cyc < 8);
        check_val({tag, "/latency"}, cyc, e_lat);
        check_val({tag, "/ok"}, 32'(result_ok), e_ok);
        check_val({tag, "/lock"}, 32'(result_lock), e_lock);
        check_val({tag, "/new_x"}, 32'(new_x), e_x);
        check_val({tag, "/new_y"}, 32'(new_y), e_y);
        check_val({tag, "/new_rot"}, 32'(new_rot), e_rot);
        check_val({tag, "/busy"}, 32'(move_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val({tag, "/hold_valid"}, 32'(result_valid), 32'd1);
            check_val({tag, "/hold_ok"}, 32'(result_ok), e_ok);
            check_val({tag, "/hold_x"}, 32'(new_x), e_x);
            check_val({tag, "/hold_rot"}, 32'(new_rot), e_rot);
            check_val({tag, "/hold_busy"}, 32'(move_ready), 32'd0);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check_val({tag, "/done_valid"}, 32'(result_valid), 32'd0);
        check_val({tag, "/done_ready"}, 32'(move_ready), 32'd1);
    endtask

    initial begin
        int r, cmd, ptype;
        clear_board();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst/move_ready", 32'(move_ready), 32'd0);
        check_val("rst/result_valid", 32'(result_valid), 32'd0);
        check_val("rst/result_ok", 32'(result_ok), 32'd0);
        check_val("rst/result_lock", 32'(result_lock), 32'd0);
        check_val("rst/piece_x", 32'(piece_x), 32'd0);
        check_val("rst/piece_y", 32'(piece_y), 32'd0);
        check_val("rst/new_x", 32'(new_x), 32'd0);
        check_val("rst/new_y", 32'(new_y), 32'd0);
        check_val("rst/new_rot", 32'(new_rot), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst/ready_after", 32'(move_ready), 32'd1);

        // T on an empty board shifts left.
        run_move(0, 2, 4, 0, 0, 0, "t_left");
        // Horizontal I at the left wall cannot shift left.
        run_move(0, 0, 0, 5, 0, 0, "i_left_wall");
        // Vertical I at the right wall cannot shift right.
        run_move(1, 0, 7, 5, 1, 0, "i_right_wall");
        // O resting on a filled bottom row must lock.
        board[BH-1] = '1;
        run_move(2, 1, 4, 17, 0, 0, "o_down_lock");
        clear_board();
        // Result held with result_ready low for five cycles.
        run_move(1, 2, 4, 5, 0, 5, "hold5");
        // Vertical I against the right wall rotating clockwise.
        run_move(3, 0, 7, 5, 1, 2, "i_rot_wall");
        run_move(4, 0, 0, 5, 3, 0, "i_rotccw_left");
        // Illegal command and illegal piece type.
        run_move(5, 2, 4, 5, 0, 1, "bad_cmd");
        run_move(0, 7, 4, 5, 0, 0, "bad_type");

        // Reset while the request is in SAMPLE.
        wait_ready("rst_sample");
        move_cmd = 3'd0; piece_type = 3'd2; cur_x = 4'd4; cur_y = 5'd3; cur_rot = 2'd0;
        move_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_sample/valid", 32'(result_valid), 32'd0);
        check_val("rst_sample/ready_in_rst", 32'(move_ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("rst_sample/no_result", 32'(result_valid), 32'd0);
        end
        check_val("rst_sample/idle", 32'(move_ready), 32'd1);

        for (int i = 0; i < 250; i++) begin
            fill_board(20);
            r = int'($urandom_range(0, 15));
            cmd = (r < 13) ? r % 5 : r - 8;
            r = int'($urandom_range(0, 15));
            ptype = (r < 14) ? r % 7 : 7;
            run_move(cmd, ptype, int'($urandom_range(0, BW - 1)), int'($urandom_range(0, BH - 2)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piece_move_resolver.md
PIECE_MOVE_RESOLVER -- requirements
Module: piece_move_resolver

Interface
REQ-001 Parameter BOARD_WIDTH, default 10, board columns.
REQ-002 Parameter BOARD_HEIGHT, default 20, board rows.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 move_valid  input  1  move request present.
REQ-006 move_ready  output  1  resolver can accept a request.
REQ-007 move_cmd  input  3  0 LEFT, 1 RIGHT, 2 DOWN, 3 ROT_CW, 4 ROT_CCW, 5-7 illegal.
REQ-008 piece_type  input  3  tetromino 0-6 (I,O,T,S,Z,J,L); 7 illegal.
REQ-009 cur_x / cur_y / cur_rot  input  $clog2(BOARD_WIDTH) / $clog2(BOARD_HEIGHT) / 2  current 4x4 piece-box origin and rotation.
REQ-010 piece_x / piece_y  output  $clog2(BOARD_WIDTH) / $clog2(BOARD_HEIGHT)  registered window origin sent to the piece mask generator.
REQ-011 window  input  [5:0] x6  window[lx][ly]; cell (piece_x+lx-1, piece_y+ly-1); off-board cells read 1.
REQ-012 result_valid  output  1  result held for the consumer.
REQ-013 result_ready  input  1  consumer accepts the result.
REQ-014 result_ok  output  1  move is legal and applied.
REQ-015 result_lock  output  1  DOWN was blocked; piece must lock.
REQ-016 new_x / new_y / new_rot  output  as cur_*  resolved position; equals latched cur_* when result_ok=0.

Function
REQ-017 FSM states IDLE, SAMPLE, CHECK, (KICK_L, KICK_R when kicks are enabled), RESP.
REQ-018 move_ready=1 only in IDLE; a handshake occurs when move_valid && move_ready.
REQ-019 On handshake: latch cmd, type, cur_*; drive piece_x=cur_x, piece_y=cur_y; go to SAMPLE.
REQ-020 SAMPLE: window settles; go to CHECK.
REQ-021 Candidate offset: LEFT dx=-1, RIGHT dx=+1, DOWN dy=+1, otherwise 0; rotation gives rot' = rot±1 mod 4, else rot'=rot.
REQ-022 Shape ROM: 16-bit mask per (type,rot), bit index sy*4+sx, sx,sy in 0..3; combinational.
REQ-023 Collision if any set shape bit has window[sx+1+dx][sy+1+dy]=1.
REQ-024 Reject without collision test if cur_x+dx<0, cur_x+dx>BOARD_WIDTH-1, or cur_y+dy>BOARD_HEIGHT-1.
REQ-025 CHECK with no collision: result_ok=1 and new_* = candidate; go to RESP.
REQ-026 CHECK with a collision: result_ok=0 and new_* = latched cur_*; result_lock=1 only for DOWN; go to RESP (or to KICK_L for a rotation with kicks enabled).
REQ-027 Illegal cmd or piece_type: result_ok=0, result_lock=0, in RESP two cycles after handshake.
REQ-028 RESP: result_valid=1 and outputs stable until result_ready; on result_ready go to IDLE; move_ready rises the next cycle.
REQ-029 Latency without kicks: handshake at cycle T -> result_valid at T+2.
REQ-030 Changes to cur_* and window outside SAMPLE/CHECK have no effect; the request is fully latched.

Reset
REQ-031 Reset in any state, mid-request included, returns the FSM to IDLE and drops the pending request.
REQ-032 Reset values: move_ready=0 during reset, 1 the first cycle after; result_valid=0, result_ok=0, result_lock=0; piece_x=0, piece_y=0; new_*=0.

Configuration
REQ-033 Macro PIECE_MOVE_RESOLVER_WALL_KICK_EN.
REQ-034 Defined: a colliding rotation retries dx=-1 (KICK_L, one cycle), then dx=+1 (KICK_R, one cycle), with the same rot'; the first pass wins; all fail -> result_ok=0; worst-case latency T+4.
REQ-035 Undefined: KICK states are absent; a colliding rotation fails immediately (T+2).

Verification
REQ-036 Empty board, T at (4,0) rot0, LEFT -> T+2 result_ok=1, new_x=3.
REQ-037 I horizontal at cur_x=0, LEFT -> result_ok=0, new_x=0 (off-board column reads 1).
REQ-038 O piece resting on a filled row, DOWN -> result_ok=0, result_lock=1, new_y unchanged.
REQ-039 result_ready held low 5 cycles -> result_valid and outputs stable, move_ready=0 throughout.
REQ-040 Reset asserted during SAMPLE -> next cycle IDLE, result_valid=0, no result issued.
REQ-041 Kick enabled: I vertical at rot1 against the right wall, ROT_CW blocked in place -> KICK_L passes, result_ok=1, new_x=cur_x-1 at T+3.
